// File: rtl/mips_core_datapath_if.sv
// Bus between the MIPS execute core and its external ROM, register file and data RAM.
// The master side is the core; the slave side is the surrounding memory system.
interface mips_core_datapath_if;
  logic [31:0] instr;
  logic [31:0] rf_dr1;
  logic [31:0] rf_dr2;
  logic [31:0] mem_rdata;
  logic        halt;
  logic [31:0] pc;
  logic [4:0]  rf_ar1;
  logic [4:0]  rf_ar2;
  logic [4:0]  rf_aw;
  logic        rf_we;
  logic [31:0] rf_dw;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        sys;

  modport master (
    input  instr, rf_dr1, rf_dr2, mem_rdata, halt,
    output pc, rf_ar1, rf_ar2, rf_aw, rf_we, rf_dw, mem_addr, mem_wdata, mem_we, sys
  );

  modport slave (
    output instr, rf_dr1, rf_dr2, mem_rdata, halt,
    input  pc, rf_ar1, rf_ar2, rf_aw, rf_we, rf_dw, mem_addr, mem_wdata, mem_we, sys
  );
endinterface

// File: rtl/mips_core_datapath.sv
// Single-cycle MIPS-subset execute core: decoder, ALU, branch/jump resolution and a
// PC register that advances on the falling clock edge.
module mips_core_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_core_datapath_if.master  bus
);
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRA = 4'd1, ALU_SRL = 4'd2, ALU_MUL = 4'd3,
                         ALU_DIV = 4'd4, ALU_ADD = 4'd5, ALU_SUB = 4'd6, ALU_AND = 4'd7,
                         ALU_OR  = 4'd8, ALU_XOR = 4'd9, ALU_NOR = 4'd10, ALU_SLT = 4'd11,
                         ALU_SLTU = 4'd12;
  localparam logic [2:0] Y_RT = 3'd0, Y_SIMM = 3'd1, Y_ZIMM = 3'd2, Y_SHAMT = 3'd3, Y_RS = 3'd4;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] simm, pc_q, pc_d, pc4, br_target, x_op, y_op, alu_r;
  logic [3:0]  alu_op;
  logic [2:0]  y_src;
  logic        x_is_rt, we, mem_we, is_sys, is_j, is_jal, is_jr, is_lw, is_lui;
  logic        br_eq, br_ne, br_lez, eq, leq, taken;

  assign op    = bus.instr[31:26];
  assign rs    = bus.instr[25:21];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign shamt = bus.instr[10:6];
  assign funct = bus.instr[5:0];
  assign imm   = bus.instr[15:0];
  assign simm  = {{16{imm[15]}}, imm};

  always_comb begin
    alu_op = ALU_ADD; y_src = Y_RT; x_is_rt = 1'b0; we = 1'b0; mem_we = 1'b0;
    is_sys = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_lw = 1'b0; is_lui = 1'b0;
    br_eq = 1'b0; br_ne = 1'b0; br_lez = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00: begin alu_op = ALU_SLL; x_is_rt = 1'b1; y_src = Y_SHAMT; we = 1'b1; end
          6'h02: begin alu_op = ALU_SRL; x_is_rt = 1'b1; y_src = Y_SHAMT; we = 1'b1; end
          6'h03: begin alu_op = ALU_SRA; x_is_rt = 1'b1; y_src = Y_SHAMT; we = 1'b1; end
          6'h04: begin alu_op = ALU_SLL; x_is_rt = 1'b1; y_src = Y_RS; we = 1'b1; end
          6'h06: begin alu_op = ALU_SRL; x_is_rt = 1'b1; y_src = Y_RS; we = 1'b1; end
          6'h07: begin alu_op = ALU_SRA; x_is_rt = 1'b1; y_src = Y_RS; we = 1'b1; end
          6'h08: is_jr = 1'b1;
          6'h0C: is_sys = 1'b1;
          6'h20, 6'h21: begin alu_op = ALU_ADD; we = 1'b1; end
          6'h22: begin alu_op = ALU_SUB;  we = 1'b1; end
          6'h24: begin alu_op = ALU_AND;  we = 1'b1; end
          6'h25: begin alu_op = ALU_OR;   we = 1'b1; end
          6'h27: begin alu_op = ALU_NOR;  we = 1'b1; end
          6'h2A: begin alu_op = ALU_SLT;  we = 1'b1; end
          6'h2B: begin alu_op = ALU_SLTU; we = 1'b1; end
          default: ;
        endcase
      end
      6'h02: is_j = 1'b1;
      6'h03: begin is_j = 1'b1; is_jal = 1'b1; we = 1'b1; end
      6'h04: br_eq = 1'b1;
      6'h05: br_ne = 1'b1;
      6'h06: br_lez = 1'b1;
      6'h08, 6'h09: begin alu_op = ALU_ADD; y_src = Y_SIMM; we = 1'b1; end
      6'h0A: begin alu_op = ALU_SLT;  y_src = Y_SIMM; we = 1'b1; end
      6'h0B: begin alu_op = ALU_SLTU; y_src = Y_ZIMM; we = 1'b1; end
      6'h0C: begin alu_op = ALU_AND;  y_src = Y_ZIMM; we = 1'b1; end
      6'h0D: begin alu_op = ALU_OR;   y_src = Y_ZIMM; we = 1'b1; end
      6'h0E: begin alu_op = ALU_XOR;  y_src = Y_ZIMM; we = 1'b1; end
      6'h0F: begin is_lui = 1'b1; we = 1'b1; end
      6'h23: begin alu_op = ALU_ADD; y_src = Y_SIMM; is_lw = 1'b1; we = 1'b1; end
      6'h2B: begin alu_op = ALU_ADD; y_src = Y_SIMM; mem_we = 1'b1; end
      default: ;
    endcase
  end

  // Shifts take the shifted value from rt and the amount from rs or shamt.
  always_comb begin
    x_op = x_is_rt ? bus.rf_dr2 : bus.rf_dr1;
    case (y_src)
      Y_SIMM:  y_op = simm;
      Y_ZIMM:  y_op = {16'h0, imm};
      Y_SHAMT: y_op = {27'h0, shamt};
      Y_RS:    y_op = bus.rf_dr1;
      default: y_op = bus.rf_dr2;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SLL:  alu_r = x_op << y_op[4:0];
      ALU_SRA:  alu_r = $signed(x_op) >>> y_op[4:0];
      ALU_SRL:  alu_r = x_op >> y_op[4:0];
      ALU_MUL:  alu_r = x_op * y_op;
      ALU_DIV:  alu_r = (y_op == 32'h0) ? 32'h0 : $signed(x_op) / $signed(y_op);
      ALU_ADD:  alu_r = x_op + y_op;
      ALU_SUB:  alu_r = x_op - y_op;
      ALU_AND:  alu_r = x_op & y_op;
      ALU_OR:   alu_r = x_op | y_op;
      ALU_XOR:  alu_r = x_op ^ y_op;
      ALU_NOR:  alu_r = ~(x_op | y_op);
      ALU_SLT:  alu_r = {31'h0, $signed(x_op) < $signed(y_op)};
      ALU_SLTU: alu_r = {31'h0, x_op < y_op};
      default:  alu_r = 32'h0;
    endcase
  end

  assign eq  = (x_op == y_op);
  assign leq = ($signed(x_op) <= $signed(y_op));

  assign pc4       = pc_q + 32'd4;
  assign br_target = pc4 + {simm[29:0], 2'b00};
  assign taken     = (br_eq & eq) | (br_ne & ~eq) | (br_lez & leq);

  always_comb begin
    if (bus.halt)      pc_d = pc_q;
    else if (is_jr)    pc_d = bus.rf_dr1;
    else if (is_j)     pc_d = {pc4[31:28], bus.instr[25:0], 2'b00};
    else if (taken)    pc_d = br_target;
    else               pc_d = pc4;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign bus.pc        = pc_q;
  assign bus.rf_ar1    = is_sys ? 5'd4 : rs;
  assign bus.rf_ar2    = is_sys ? 5'd2 : rt;
  assign bus.rf_aw     = is_jal ? 5'd31 : ((op == 6'h00) ? rd : rt);
  assign bus.rf_we     = we;
  assign bus.rf_dw     = is_lui ? {imm, 16'h0} : is_jal ? pc4 : is_lw ? bus.mem_rdata : alu_r;
  assign bus.mem_addr  = alu_r[11:2];
  assign bus.mem_wdata = bus.rf_dr2;
  assign bus.mem_we    = mem_we;
  assign bus.sys       = is_sys;
endmodule

// File: tb/tb_mips_core_datapath.sv
// Directed checks of the MIPS execute core: reset, decode, ALU, branches, jumps, halt.
module tb_mips_core_datapath;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_pc;

  mips_core_datapath_if bus ();
  mips_core_datapath #(.RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
    bus.instr  = ins;
    bus.rf_dr1 = d1;
    bus.rf_dr2 = d2;
    #1;
  endtask

  task automatic nops(input int n);
    apply(32'h0, 32'h0, 32'h0);
    repeat (n) begin
      tick();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr = 32'h0; bus.rf_dr1 = 32'h0; bus.rf_dr2 = 32'h0;
    bus.mem_rdata = 32'h0; bus.halt = 1'b0;
    #12;
    chk("reset_pc", bus.pc, 32'h0);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    nops(3);
    chk("pc_after_3", bus.pc, 32'hC);

    // Asynchronous reset mid-run, away from any clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_reset", bus.pc, 32'h0);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    nops(4);
    chk("pc_0x10", bus.pc, exp_pc);

    apply({6'h08, 5'd0, 5'd8, 16'hFFFB}, 32'h0, 32'h0);
    chk("addi_aw", {27'h0, bus.rf_aw}, 32'd8);
    chk("addi_we", {31'h0, bus.rf_we}, 32'd1);
    chk("addi_dw", bus.rf_dw, 32'hFFFF_FFFB);
    chk("addi_mwe", {31'h0, bus.mem_we}, 32'd0);

    apply({6'h0D, 5'd0, 5'd9, 16'h8000}, 32'h0, 32'h0);
    chk("ori_aw", {27'h0, bus.rf_aw}, 32'd9);
    chk("ori_dw", bus.rf_dw, 32'h0000_8000);

    apply({6'h04, 5'd1, 5'd2, 16'hFFFE}, 32'd7, 32'd7);
    chk("beq_we", {31'h0, bus.rf_we}, 32'd0);
    tick();
    chk("beq_pc", bus.pc, 32'h0C);
    exp_pc = 32'h0C;
    nops(1);
    apply({6'h05, 5'd1, 5'd2, 16'hFFFE}, 32'd7, 32'd7);
    tick();
    chk("bne_pc", bus.pc, 32'h14);

    // blez on a negative rs is taken: 0x14 + 4 + 16.
    apply({6'h06, 5'd1, 5'd0, 16'h0004}, 32'hFFFF_FFFF, 32'h0);
    tick();
    chk("blez_pc", bus.pc, 32'h28);
    exp_pc = 32'h28;
    nops(6);
    chk("pc_0x40", bus.pc, 32'h40);

    apply({6'h03, 26'h100}, 32'h0, 32'h0);
    chk("jal_aw", {27'h0, bus.rf_aw}, 32'd31);
    chk("jal_we", {31'h0, bus.rf_we}, 32'd1);
    chk("jal_dw", bus.rf_dw, 32'h44);
    tick();
    chk("jal_pc", bus.pc, 32'h400);

    apply({6'h00, 5'd31, 15'h0, 6'h08}, 32'h44, 32'h0);
    chk("jr_we", {31'h0, bus.rf_we}, 32'd0);
    tick();
    chk("jr_pc", bus.pc, 32'h44);

    apply({6'h00, 5'd0, 5'd1, 5'd3, 5'd4, 6'h03}, 32'h0, 32'h8000_0000);
    chk("sra_aw", {27'h0, bus.rf_aw}, 32'd3);
    chk("sra_dw", bus.rf_dw, 32'hF800_0000);
    apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h04}, 32'd4, 32'd1);
    chk("sllv_dw", bus.rf_dw, 32'd16);
    apply({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2B}, 32'd1, 32'hFFFF_FFFF);
    chk("sltu_dw", bus.rf_dw, 32'd1);
    apply({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2A}, 32'd1, 32'hFFFF_FFFF);
    chk("slt_dw", bus.rf_dw, 32'd0);
    apply({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h22}, 32'd3, 32'd5);
    chk("sub_dw", bus.rf_dw, 32'hFFFF_FFFE);

    bus.mem_rdata = 32'hDEAD_BEEF;
    apply({6'h23, 5'd1, 5'd5, 16'h0008}, 32'h100, 32'h0);
    chk("lw_addr", {22'h0, bus.mem_addr}, 32'h42);
    chk("lw_dw", bus.rf_dw, 32'hDEAD_BEEF);
    chk("lw_aw", {27'h0, bus.rf_aw}, 32'd5);
    apply({6'h2B, 5'd1, 5'd6, 16'h0004}, 32'h20, 32'h1234_5678);
    chk("sw_addr", {22'h0, bus.mem_addr}, 32'h9);
    chk("sw_mwe", {31'h0, bus.mem_we}, 32'd1);
    chk("sw_we", {31'h0, bus.rf_we}, 32'd0);
    chk("sw_wdata", bus.mem_wdata, 32'h1234_5678);
    apply({6'h0F, 5'd0, 5'd7, 16'h1234}, 32'h0, 32'h0);
    chk("lui_dw", bus.rf_dw, 32'h1234_0000);

    bus.halt = 1'b1;
    apply({6'h00, 20'h0, 6'h0C}, 32'h0, 32'h0);
    chk("sys", {31'h0, bus.sys}, 32'd1);
    chk("sys_ar1", {27'h0, bus.rf_ar1}, 32'd4);
    chk("sys_ar2", {27'h0, bus.rf_ar2}, 32'd2);
    chk("sys_we", {31'h0, bus.rf_we}, 32'd0);
    repeat (5) tick();
    chk("halt_pc", bus.pc, 32'h44);

    bus.halt = 1'b0;
    apply({6'h3F, 26'h3FF_FFFF}, 32'h0, 32'h0);
    chk("unk_we", {31'h0, bus.rf_we}, 32'd0);
    chk("unk_mwe", {31'h0, bus.mem_we}, 32'd0);
    tick();
    chk("unk_pc", bus.pc, 32'h48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
